// File: rtl/gf_op_scheduler.sv
// gf_op_scheduler: fetches per-command opcode programs and issues them to Core1 (square/xor/reduce)
// and Core2 (pipelined multiply with FIFO credit tracking). Macro GF_SCHED_PERF_CNT_EN adds cycle_cnt.
//
// state | meaning
// IDLE  | waiting for start; command and pc latched on accept
// FETCH | rom_addr driven, opcode arrives next cycle
// ISSUE | decode opcode from ROM and issue / branch
// STALL | MUL held until Core2 has room and credit is available
// DRAIN | wait for outstanding==0 (after WAIT, or after END before DONE)
// DONE  | one-cycle done pulse, back to IDLE
module gf_op_scheduler #(
   parameter int PC_W    = 6,
   parameter int MAX_OUT = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [5:0]        command,
   output logic              busy,
   output logic              done,
   output logic [6+PC_W-1:0] rom_addr,
   input  logic [15:0]       rom_opcode,
   output logic              core1_valid,
   output logic [1:0]        core1_cmd,
   output logic              core2_wr_en,
   output logic [7:0]        core2_cmd,
   input  logic              core2_in_busy,
   input  logic              core2_out_busy,
   output logic              core2_rd_en,
`ifdef GF_SCHED_PERF_CNT_EN
   output logic [15:0]       cycle_cnt,
`endif
   output logic [3:0]        outstanding
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_ISSUE, S_STALL, S_DRAIN, S_DONE
   } state_t;

   localparam logic [3:0]      C_END  = 4'd0;
   localparam logic [3:0]      C_MUL  = 4'd1;
   localparam logic [3:0]      C_SQR  = 4'd2;
   localparam logic [3:0]      C_XOR  = 4'd3;
   localparam logic [3:0]      C_RED  = 4'd4;
   localparam logic [3:0]      C_WAIT = 4'd5;
   localparam logic [PC_W-1:0] LP_PC_ONE  = 1;
   localparam logic [4:0]      LP_MAX_OUT = 5'(MAX_OUT);

   state_t          r_state;
   logic [PC_W-1:0] r_pc;
   logic [5:0]      r_cmd;
   logic [15:0]     r_op;
   logic            r_end_pend;
   logic [3:0]      r_outst;
   logic            r_busy;
   logic            r_done;

   logic [15:0]     w_op;
   logic [3:0]      w_class;
   logic            w_exec;
   logic            w_push;
   logic            w_pop;
   logic            w_core1;
   logic            w_unused_bits;

   // ROM data is only valid in ISSUE; a stalled MUL replays from the held copy
   assign w_op    = (r_state == S_ISSUE) ? rom_opcode : r_op;
   assign w_class = w_op[15:12];
   assign w_exec  = (r_state == S_ISSUE) || (r_state == S_STALL);
   assign w_push  = w_exec && (w_class == C_MUL) && !core2_in_busy
                    && ({1'b0, r_outst} < LP_MAX_OUT);
   assign w_pop   = !core2_out_busy && (r_outst != 4'd0);
   assign w_core1 = (r_state == S_ISSUE)
                    && ((w_class == C_SQR) || (w_class == C_XOR) || (w_class == C_RED));
   assign w_unused_bits = ^{w_op[11], w_op[3], w_op[0]};

   assign busy        = r_busy;
   assign done        = r_done;
   assign rom_addr    = {r_cmd, r_pc};
   assign outstanding = r_outst;
   assign core1_valid = w_core1;
   assign core1_cmd   = w_op[5:4];
   assign core2_wr_en = w_push;
   assign core2_cmd   = {w_op[8:6], w_op[10:9], w_op[2:1], 1'b0};
   assign core2_rd_en = w_pop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_pc       <= '0;
         r_cmd      <= '0;
         r_op       <= '0;
         r_end_pend <= 1'b0;
         r_outst    <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_cmd   <= command;
                  r_pc    <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_FETCH;
               end
            end
            S_FETCH: r_state <= S_ISSUE;
            S_ISSUE: begin
               r_op <= rom_opcode;
               case (w_class)
                  C_END: begin
                     if (r_outst == 4'd0) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                     end else begin
                        r_end_pend <= 1'b1;
                        r_state    <= S_DRAIN;
                     end
                  end
                  C_MUL: begin
                     if (w_push) begin
                        r_pc    <= r_pc + LP_PC_ONE;
                        r_state <= S_FETCH;
                     end else begin
                        r_state <= S_STALL;
                     end
                  end
                  C_WAIT: begin
                     r_end_pend <= 1'b0;
                     r_state    <= S_DRAIN;
                  end
                  default: begin
                     r_pc    <= r_pc + LP_PC_ONE;
                     r_state <= S_FETCH;
                  end
               endcase
            end
            S_STALL: begin
               if (w_push) begin
                  r_pc    <= r_pc + LP_PC_ONE;
                  r_state <= S_FETCH;
               end
            end
            S_DRAIN: begin
               if (r_outst == 4'd0) begin
                  if (r_end_pend) begin
                     r_end_pend <= 1'b0;
                     r_done     <= 1'b1;
                     r_state    <= S_DONE;
                  end else begin
                     r_pc    <= r_pc + LP_PC_ONE;
                     r_state <= S_FETCH;
                  end
               end
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase

         case ({w_push, w_pop})
            2'b10:   r_outst <= r_outst + 4'd1;
            2'b01:   r_outst <= r_outst - 4'd1;
            default: r_outst <= r_outst;
         endcase
      end
   end

`ifdef GF_SCHED_PERF_CNT_EN
   logic [15:0] r_cycle_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cycle_cnt <= '0;
      end else if ((r_state == S_IDLE) && start) begin
         r_cycle_cnt <= '0;
      end else if (r_busy && (r_cycle_cnt != 16'hFFFF)) begin
         r_cycle_cnt <= r_cycle_cnt + 16'd1;
      end
   end

   assign cycle_cnt = r_cycle_cnt;
`endif

endmodule

// File: doc/gf_op_scheduler.md
GF_OP_SCHEDULER -- requirements
Module: gf_op_scheduler

Interface
REQ-001 Parameter PC_W, default 6: per-command program offset width; program length ≤ 2^PC_W opcodes.
REQ-002 Parameter MAX_OUT, default 8: max outstanding Core2 multiplies (matches Core2 FIFO depth).
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  one-cycle pulse; launches program selected by command.
REQ-006 command  in  6  program select; sampled only on accepted start.
REQ-007 busy  out  1  high from accepted start until done.
REQ-008 done  out  1  one-cycle pulse at program completion.
REQ-009 rom_addr  out  6+PC_W  {command_latched, pc}; opcode returns next cycle.
REQ-010 rom_opcode  in  16  opcode: [15:12] class, [10:9] srcB, [8:6] dest, [5:4] core1 sub-cmd, [2:1] srcA.
REQ-011 core1_valid  out  1  one-cycle issue strobe to Core1 (square/xor/reduce).
REQ-012 core1_cmd  out  2  Core1 sub-command, copy of opcode[5:4].
REQ-013 core2_wr_en  out  1  one-cycle push of a multiply into Core2 input and command FIFOs.
REQ-014 core2_cmd  out  8  {opcode[8:6], opcode[10:9], opcode[2:1], 1'b0}.
REQ-015 core2_in_busy  in  1  Core2 input FIFO full; no push while high.
REQ-016 core2_out_busy  in  1  Core2 output FIFO empty.
REQ-017 core2_rd_en  out  1  pop one Core2 result.
REQ-018 outstanding  out  4  count of multiplies issued, not yet popped.

Function
REQ-019 Classes: 0 END, 1 MUL, 2 SQR, 3 XOR, 4 RED, 5 WAIT, 6-15 NOP (pc advances, no issue).
REQ-020 States: IDLE, FETCH, ISSUE, STALL, DRAIN, DONE.
REQ-021 IDLE: start latches command, pc←0 -> FETCH; start ignored in every other state.
REQ-022 FETCH: drive rom_addr -> ISSUE next cycle (1-cycle ROM latency).
REQ-023 ISSUE SQR/XOR/RED: core1_valid=1 for that cycle, pc+1 -> FETCH; issue rate is one opcode per 2 cycles.
REQ-024 ISSUE MUL with core2_in_busy=0 and outstanding<MAX_OUT: core2_wr_en=1, outstanding+1, pc+1 -> FETCH; otherwise -> STALL, opcode held.
REQ-025 STALL: re-evaluates the REQ-024 condition every cycle; issues and -> FETCH on the first cycle it holds.
REQ-026 ISSUE WAIT: -> DRAIN; DRAIN -> FETCH with pc+1 when outstanding==0.
REQ-027 ISSUE END: -> DRAIN-like wait until outstanding==0, then -> DONE; DONE pulses done for 1 cycle -> IDLE.
REQ-028 core2_rd_en = (core2_out_busy==0) && (outstanding!=0) in any state, combinational.
REQ-029 Pop and push in the same cycle: outstanding unchanged.
REQ-030 pc at 2^PC_W-1 without END: wraps to 0, no error flag.
REQ-031 core2_in_busy never overrides a push already asserted in an earlier cycle; push is gated in the same cycle only.

Reset
REQ-032 rst_n low: state IDLE, pc 0, command_latched 0, outstanding 0; all strobes, busy and done 0; takes effect immediately, mid-program included.
REQ-033 Results still in Core2 at reset are discarded by the Core2 owner; scheduler does not drain them.

Configuration
REQ-034 Macro GF_SCHED_PERF_CNT_EN defined: adds output cycle_cnt[15:0], cleared on accepted start, +1 per busy cycle, saturates at FFFF, held after done, reset to 0.
REQ-035 Macro undefined: no cycle_cnt port or logic; all other behaviour identical.

Verification
REQ-036 Program SQR,XOR,END on command 3 -> rom_addr 0xC0,0xC1,0xC2; core1_valid at cycles 2 and 4 after start; done 7 cycles after start.
REQ-037 Three MULs, core2_in_busy held high 5 cycles on 2nd -> 2nd push delayed exactly 5 cycles; outstanding peaks at 3.
REQ-038 Nine MULs with no pops -> 9th stalls at outstanding=8 until first pop, then issues.
REQ-039 MUL,WAIT,SQR, result returned 10 cycles later -> core1_valid for SQR only after outstanding returns to 0.
REQ-040 rst_n low during STALL -> busy, strobes, outstanding zero same cycle; new start after release runs cleanly.
REQ-041 Simultaneous pop and push at outstanding=4 -> outstanding stays 4.
